maj5_vote_arbiter: RTL
======================

Name: maj5_vote_arbiter

Overview:
- Shares one 5-input majority evaluator among NUM_REQ requesters; each requester submits a 5-bit vote vector over a valid/ready handshake.
- A round-robin arbiter admits at most one vector per cycle.
- The majority result, popcount and requester tag are registered into a one-deep output slot with backpressure.
- Sits in front of the shared majority datapath. The evaluator itself is combinational; this block supplies all sequencing, fairness and buffering.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TAG_W, $clog2(NUM_REQ), width of the requester index.
- CNT_W, 16, width of the wrapping evaluation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester vote-vector valid.
- req_vote  input  5*NUM_REQ  vote vectors; requester i occupies bits [5i+4:5i], bit 0 maps to evaluator input pi0.
- req_ready  output  NUM_REQ  one-hot-or-zero accept strobe.
- res_valid  output  1  output slot occupied.
- res_ready  input  1  consumer accepts the result.
- res_maj  output  1  majority of the accepted vector (popcount >= 3).
- res_count  output  3  popcount of the accepted vector, 0..5.
- res_tag  output  TAG_W  index of the requester that was served.
- eval_count  output  CNT_W  total accepted vectors since reset.

Behaviour:
- Reset, asynchronous: res_valid=0, res_maj=0, res_count=0, res_tag=0, eval_count=0, rr_ptr=0, req_ready=0.
  - Reset asserted mid-transfer discards the held result and any in-flight grant.
- Slot states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- Slot is "free" when the state is EMPTY, or when it is FULL and res_ready=1 (drain and refill in the same cycle).
- Arbitration (combinational, same cycle):
  - If the slot is free, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - If the slot is not free, req_ready=0.
  - req_ready never depends on req_valid of the same requester beyond grant selection; no combinational path from res_ready into req_vote.
- Accept, when req_valid[g] & req_ready[g]:
  - On the next edge: res_maj, res_count = majority/popcount(req_vote[g]); res_tag=g; res_valid=1; rr_ptr=(g+1) mod NUM_REQ; eval_count += 1, wrapping from 2^CNT_W-1 to 0.
- Latency: result is visible exactly 1 cycle after acceptance.
- Throughput: 1 vector/cycle while res_ready=1.
- Drain without refill: FULL & res_ready & no grant -> EMPTY next cycle. res_maj, res_count and res_tag keep their last values.
- Stall: FULL & !res_ready -> all result outputs held stable; rr_ptr held; no requester accepted.
- No requests pending: rr_ptr unchanged.
- Requester protocol (the bench checks; the block does not enforce):
  - req_valid must not drop while waiting.
  - req_vote must be stable while req_valid=1 and req_ready=0.

Decomposition:
- Package maj5_pkg:
  - VOTE_W=5 and MAJ_THRESH=3.
  - Typedef vote_t (logic [4:0]).
  - Function popcount5 returning logic [2:0].
- Sub-module maj5_eval (combinational): vote_t in -> maj, count.
  - Functionally identical to the existing 5-input majority netlist, so it can be swapped for it in equivalence checks.
- Round-robin grant logic stays inline in maj5_vote_arbiter.

Test Plan:
- Reset mid-stall: fill the slot, hold res_ready=0, assert rst -> res_valid=0, eval_count=0, rr_ptr=0; with req_valid=4'b1000 and the slot free, the first grant goes to requester 3.
- Single requester, NUM_REQ=4: req_valid=4'b0001, vote 5'b10110, res_ready=1 -> next cycle res_valid=1, res_maj=1, res_count=3, res_tag=0; vote 5'b10010 -> res_maj=0, res_count=2.
- Fairness: req_valid=4'b1111 held, res_ready=1 for 8 cycles -> res_tag sequence 0,1,2,3,0,1,2,3; eval_count=8.
- Backpressure: slot FULL with tag 1, res_ready=0 for 3 cycles with req_valid=4'b0101 -> req_ready=0 and outputs stable for those cycles; on res_ready=1, the same-cycle refill grants requester 2.
- Boundary votes: 5'b00000 -> maj 0, count 0; 5'b11111 -> maj 1, count 5; 5'b00111 -> maj 1, count 3.
  - Exhaustive 32-vector sweep compared against popcount>=3.
- Counter wrap, CNT_W=4: 17 accepts -> eval_count reads 1.

Source files
------------

// File: rtl/maj5_pkg.sv
// Shared types and helpers for the 5-input majority vote path.
// Latency: n/a (package).
// Backpressure: n/a (package).
package maj5_pkg;

  localparam int         VOTE_W     = 5;
  localparam logic [2:0] MAJ_THRESH = 3'd3;

  typedef logic [VOTE_W-1:0] vote_t;

  // One-deep result slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [2:0] popcount5(input vote_t v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < VOTE_W; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/maj5_eval.sv
// Combinational 5-input majority evaluator: popcount and popcount >= 3.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: vote (5-bit vector, bit 0 = pi0) -> maj, count (0..5).
module maj5_eval
  import maj5_pkg::*;
(
  input  vote_t      vote,
  output logic       maj,
  output logic [2:0] count
);

  always_comb begin
    count = popcount5(vote);
    maj   = (count >= MAJ_THRESH);
  end

endmodule

// File: rtl/maj5_vote_arbiter.sv
// Round-robin arbiter sharing one majority evaluator among NUM_REQ requesters.
// Latency: result registered 1 cycle after accept; 1 vector/cycle sustained.
// Backpressure: one-deep result slot; req_ready low while slot FULL and !res_ready.
// Ports: req_valid/req_vote/req_ready (per-requester handshake, 5 bits each),
//        res_valid/res_ready/res_maj/res_count/res_tag (result slot),
//        eval_count (wrapping count of accepted vectors).
module maj5_vote_arbiter
  import maj5_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [VOTE_W*NUM_REQ-1:0] req_vote,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_maj,
  output logic [2:0]                res_count,
  output logic [TAG_W-1:0]          res_tag,
  output logic [CNT_W-1:0]          eval_count
);

  slot_state_e      state;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] next_ptr;
  logic [TAG_W:0]   scan_idx;
  logic             grant_vld;
  logic             slot_free;
  logic             accept;
  vote_t            votes [NUM_REQ];
  vote_t            sel_vote;
  logic             eval_maj;
  logic [2:0]       eval_cnt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      votes[i] = req_vote[VOTE_W*i +: VOTE_W];
    end
  end

  // Scan starting at rr_ptr; one extra bit on scan_idx lets the modulo wrap
  // be a single conditional subtract, valid for non-power-of-two NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      if (scan_idx >= (TAG_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (TAG_W+1)'(NUM_REQ);
      end
      if (!grant_vld && req_valid[scan_idx[TAG_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[TAG_W-1:0];
      end
    end
  end

  // Drain-and-refill in one cycle when the consumer takes the held result.
  // Reset also suppresses grants so nothing is accepted while rst is high.
  assign slot_free = !rst && ((state == SLOT_EMPTY) || res_ready);
  assign accept    = slot_free && grant_vld;
  assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign sel_vote  = votes[grant_idx];
  assign next_ptr  = (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  assign res_valid = (state == SLOT_FULL);

  maj5_eval u_eval (
    .vote  (sel_vote),
    .maj   (eval_maj),
    .count (eval_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SLOT_EMPTY;
      res_maj    <= 1'b0;
      res_count  <= 3'd0;
      res_tag    <= '0;
      rr_ptr     <= '0;
      eval_count <= '0;
    end else begin
      if (accept) begin
        state      <= SLOT_FULL;
        res_maj    <= eval_maj;
        res_count  <= eval_cnt;
        res_tag    <= grant_idx;
        rr_ptr     <= next_ptr;
        eval_count <= eval_count + 1'b1;
      end else if (res_ready) begin
        // Drain without refill: result fields keep their last values.
        state <= SLOT_EMPTY;
      end
    end
  end

endmodule
